riscv_irq_ctrl: RTL and testbench
=================================

RISCV_IRQ_CTRL -- requirements
Module: riscv_irq_ctrl

Interface
REQ-001 Parameter NUM_LOCAL, default 8: number of local interrupt sources; legal range 1..16.
REQ-002 Parameter LOCAL_EDGE, default all zeros, NUM_LOCAL bits: per-local-source mode; 1 = rising-edge latched, 0 = level.
REQ-003 Parameter NW = 3+NUM_LOCAL, derived, not overridable: width of the pending and enable vectors.
REQ-004 clk_i  in  1  single clock; all state updates on the rising edge.
REQ-005 rst_ni  in  1  asynchronous, active-low reset.
REQ-006 gie_i  in  1  global interrupt enable (mstatus.MIE).
REQ-007 mie_i  in  NW  per-source enable; bit0 MSI, bit1 MTI, bit2 MEI, bit 3+i local i.
REQ-008 sw_irq_i, timer_irq_i, ext_irq_i  in  1 each  level sources.
REQ-009 l_irq_i  in  NUM_LOCAL  local sources.
REQ-010 irq_ack_i  in  1  core accepts the presented interrupt.
REQ-011 mret_i  in  1  core returns from the handler.
REQ-012 mip_o  out  NW  registered pending vector.
REQ-013 irq_req_o  out  1  interrupt request to the core.
REQ-014 irq_cause_o  out  5  mcause exception code of the presented interrupt.

Function
REQ-015 Level sources shall be sampled into mip_o every cycle, giving 1 cycle latency from input to mip_o.
REQ-016 An edge-mode local shall set its mip_o bit on a 0->1 transition of its input, judged against a registered previous value, and hold the bit until that source is acknowledged.
REQ-017 If an edge set and an ack clear hit the same bit in the same cycle, the set shall win.
REQ-018 Priority shall be: highest-index enabled pending local first, then MEI, then MSI, then MTI.
REQ-019 Cause codes shall be: local i = 16+i, MEI = 11, MSI = 3, MTI = 7.
REQ-020 The state machine shall have three states: IDLE, REQ and BUSY.
REQ-021 IDLE->REQ when gie_i=1 and (mie_i & mip_o) is nonzero; on that transition the winning source index and cause shall be latched.
REQ-022 In REQ, irq_req_o=1 and irq_cause_o shall stay frozen until irq_ack_i, even if the source drops or gie_i falls.
REQ-023 REQ->BUSY on irq_ack_i.
REQ-024 On the REQ->BUSY transition the latched source's mip_o bit shall clear if that source is edge-mode.
REQ-025 BUSY->IDLE on mret_i; no new request shall be raised while in BUSY, so there is no nesting.
REQ-026 irq_ack_i outside REQ and mret_i outside BUSY shall be ignored.
REQ-027 The earliest re-request after mret_i shall be the following cycle: IDLE evaluation occurs on the cycle after returning to IDLE.
REQ-028 Minimum request latency shall be 2 cycles from a source input rising to irq_req_o=1.

Reset
REQ-029 While rst_ni=0, the block shall be held as follows: state IDLE, mip_o=0, previous-edge registers 0, irq_req_o=0, irq_cause_o=0, latched index 0.
REQ-030 Reset asserted mid-REQ or mid-BUSY shall abort to IDLE immediately and discard any pending edge.

Configuration
REQ-031 Macro RISCV_IRQ_SYNC_EN, when defined, shall insert a 2-flop synchroniser on every source input before sampling, reset to 0 by rst_ni.
REQ-032 With RISCV_IRQ_SYNC_EN defined, all source latencies shall increase by 2 cycles: mip_o at 3 cycles, irq_req_o at 4 cycles minimum.
REQ-033 Without RISCV_IRQ_SYNC_EN, source inputs shall be sampled directly and the latencies of REQ-015 and REQ-028 shall apply.

Structure
REQ-034 Package riscv_irq_pkg shall hold the cause constants (CAUSE_MSI=3, CAUSE_MTI=7, CAUSE_MEI=11, CAUSE_LOCAL_BASE=16), the state enum type, and bit-position constants for MSI, MTI and MEI.
REQ-035 Sub-module riscv_irq_sync shall implement the parametrised-width 2-flop synchroniser, instantiated only under RISCV_IRQ_SYNC_EN.
REQ-036 The priority encoder shall be a combinational function inside riscv_irq_ctrl.

Verification
REQ-037 The bench shall cover: NUM_LOCAL=8, gie=1, mie all ones, ext_irq_i=1 and l_irq_i[5]=1 in the same cycle -> irq_req_o=1 after 2 cycles with cause 21; after ack, no request until mret.
REQ-038 The bench shall cover: l_irq_i[7:0]=8'h81 -> cause 23 (index 7 beats index 0).
REQ-039 The bench shall cover: LOCAL_EDGE[2]=1, a 1-cycle pulse on l_irq_i[2] -> mip_o[5] stays 1 until ack, then clears; cause 18.
REQ-040 The bench shall cover: edge re-pulse on l_irq_i[2] in the same cycle as its ack -> mip_o[5] remains 1, and a new request with cause 18 follows the next mret.
REQ-041 The bench shall cover: request raised with cause 7, then timer_irq_i dropped and gie_i=0 before ack -> irq_req_o stays 1 with cause 7 until ack.
REQ-042 The bench shall cover: rst_ni pulled low while in BUSY -> all outputs 0 asynchronously, and after release a request is raised without mret_i.

Source files
------------

// File: rtl/riscv_irq_pkg.sv
// Shared constants and types for the RISC-V machine-mode interrupt controller.
package riscv_irq_pkg;

    // mcause exception codes (interrupt bit is added by the core)
    localparam logic [4:0] CAUSE_MSI        = 5'd3;
    localparam logic [4:0] CAUSE_MTI        = 5'd7;
    localparam logic [4:0] CAUSE_MEI        = 5'd11;
    localparam logic [4:0] CAUSE_LOCAL_BASE = 5'd16;

    // bit positions inside mip/mie; local i sits at 3+i
    localparam int BIT_MSI = 0;
    localparam int BIT_MTI = 1;
    localparam int BIT_MEI = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_BUSY = 2'd2
    } irq_state_e;

endpackage

// File: rtl/riscv_irq_ctrl_if.sv
// Core-side handshake of the interrupt controller: request/cause out, ack/mret in.
interface riscv_irq_ctrl_if;
    logic       irq_req_o;
    logic [4:0] irq_cause_o;
    logic       irq_ack_i;
    logic       mret_i;

    // controller side
    modport master (output irq_req_o, irq_cause_o, input irq_ack_i, mret_i);
    // core side
    modport slave  (input irq_req_o, irq_cause_o, output irq_ack_i, mret_i);
endinterface

// File: rtl/riscv_irq_sync.sv
// W-bit two-flop synchroniser for asynchronous interrupt sources.
module riscv_irq_sync #(
    parameter int W = 1
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);
    logic [W-1:0] ff1_q, ff2_q;

    // two back-to-back flops, cleared by reset
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ff1_q <= '0;
            ff2_q <= '0;
        end else begin
            ff1_q <= d_i;
            ff2_q <= ff1_q;
        end
    end

    assign q_o = ff2_q;
endmodule

// File: rtl/riscv_irq_ctrl.sv
// Machine-mode interrupt controller: pending register, fixed priority,
// IDLE/REQ/BUSY handshake with the core (no nesting).
// Define RISCV_IRQ_SYNC_EN to put a 2-flop synchroniser on every source.
module riscv_irq_ctrl
    import riscv_irq_pkg::*;
#(
    parameter int                   NUM_LOCAL  = 8,
    parameter logic [NUM_LOCAL-1:0] LOCAL_EDGE = '0,
    localparam int                  NW         = 3 + NUM_LOCAL
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 gie_i,
    input  logic [NW-1:0]        mie_i,
    input  logic                 sw_irq_i,
    input  logic                 timer_irq_i,
    input  logic                 ext_irq_i,
    input  logic [NUM_LOCAL-1:0] l_irq_i,
    output logic [NW-1:0]        mip_o,
    riscv_irq_ctrl_if.master     core
);
    localparam logic [NW-1:0] EDGE_MASK = {LOCAL_EDGE, 3'b000};

    logic [NW-1:0] src_raw, src_s;
    logic [NW-1:0] prev_q, mip_q, mip_d, edge_set, ack_clr;
    irq_state_e    state_q, state_d;
    logic [4:0]    idx_q, idx_d, cause_q, cause_d;
    logic [5:0]    pick;

    assign src_raw = {l_irq_i, ext_irq_i, timer_irq_i, sw_irq_i};

`ifdef RISCV_IRQ_SYNC_EN
    riscv_irq_sync #(.W(NW)) u_sync (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .d_i    (src_raw),
        .q_o    (src_s)
    );
`else
    assign src_s = src_raw;
`endif

    // {valid, index}: later assignments override, so the last one is highest priority
    function automatic logic [5:0] prio_pick(input logic [NW-1:0] v);
        logic [5:0] r;
        r = '0;
        if (v[BIT_MTI]) r = {1'b1, 5'(BIT_MTI)};
        if (v[BIT_MSI]) r = {1'b1, 5'(BIT_MSI)};
        if (v[BIT_MEI]) r = {1'b1, 5'(BIT_MEI)};
        for (int i = 0; i < NUM_LOCAL; i++)
            if (v[3+i]) r = {1'b1, 5'(3 + i)};
        return r;
    endfunction

    function automatic logic [4:0] idx2cause(input logic [4:0] idx);
        if (idx == 5'(BIT_MSI))      return CAUSE_MSI;
        else if (idx == 5'(BIT_MTI)) return CAUSE_MTI;
        else if (idx == 5'(BIT_MEI)) return CAUSE_MEI;
        else                         return CAUSE_LOCAL_BASE + idx - 5'd3;
    endfunction

    // pending vector: level bits follow the input, edge bits latch until acked (set wins)
    always_comb begin
        ack_clr  = '0;
        if (state_q == ST_REQ && core.irq_ack_i) ack_clr = NW'(1) << idx_q;
        edge_set = src_s & ~prev_q;
        mip_d    = (~EDGE_MASK & src_s) |
                   (EDGE_MASK & (edge_set | (mip_q & ~ack_clr)));
    end

    // next state and request latching
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cause_d = cause_q;
        pick    = prio_pick(mie_i & mip_q);
        case (state_q)
            ST_IDLE: if (gie_i && pick[5]) begin
                state_d = ST_REQ;
                idx_d   = pick[4:0];
                cause_d = idx2cause(pick[4:0]);
            end
            ST_REQ:  if (core.irq_ack_i) state_d = ST_BUSY;
            ST_BUSY: if (core.mret_i)    state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // state, pending and edge-history registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            cause_q <= '0;
            mip_q   <= '0;
            prev_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cause_q <= cause_d;
            mip_q   <= mip_d;
            prev_q  <= src_s;
        end
    end

    assign mip_o            = mip_q;
    assign core.irq_req_o   = (state_q == ST_REQ);
    assign core.irq_cause_o = cause_q;
endmodule

// File: tb/tb_riscv_irq_ctrl.sv
`timescale 1ns/1ps
module tb_riscv_irq_ctrl;
  localparam int NL = 8;
  localparam int NW = 3 + NL;

  logic          clk = 1'b0;
  logic          rst_ni;
  logic          gie;
  logic [NW-1:0] mie;
  logic          sw, tmr, ext;
  logic [NL-1:0] lirq;
  logic [NW-1:0] mip;
  int            checks = 0;
  int            errors = 0;

  riscv_irq_ctrl_if core_if ();

  riscv_irq_ctrl #(.NUM_LOCAL(NL), .LOCAL_EDGE(8'b0000_0100)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_ni),
    .gie_i       (gie),
    .mie_i       (mie),
    .sw_irq_i    (sw),
    .timer_irq_i (tmr),
    .ext_irq_i   (ext),
    .l_irq_i     (lirq),
    .mip_o       (mip),
    .core        (core_if)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_ni = 1'b0; gie = 1'b0; mie = '0;
    sw = 1'b0; tmr = 1'b0; ext = 1'b0; lirq = '0;
    core_if.irq_ack_i = 1'b0; core_if.mret_i = 1'b0;
    #2;
    chk("rst_req",   core_if.irq_req_o,   1'b0);
    chk("rst_cause", core_if.irq_cause_o, 5'd0);
    chk("rst_mip",   mip,                 11'h000);
    tick(); tick();
    rst_ni = 1'b1;
    gie = 1'b1; mie = '1;

    ext = 1'b1; lirq = 8'h20;
    tick();
    chk("t1_mip",     mip,               11'h104);
    chk("t1_req_lat", core_if.irq_req_o, 1'b0);
    tick();
    chk("t1_req",   core_if.irq_req_o,   1'b1);
    chk("t1_cause", core_if.irq_cause_o, 5'd21);
    core_if.irq_ack_i = 1'b1; tick(); core_if.irq_ack_i = 1'b0;
    chk("t1_busy", core_if.irq_req_o, 1'b0);
    tick(); tick(); tick();
    chk("t1_nonest", core_if.irq_req_o, 1'b0);
    core_if.mret_i = 1'b1; tick(); core_if.mret_i = 1'b0;
    chk("t1_idle", core_if.irq_req_o, 1'b0);
    tick();
    chk("t1_rereq",  core_if.irq_req_o,   1'b1);
    chk("t1_rcause", core_if.irq_cause_o, 5'd21);
    core_if.irq_ack_i = 1'b1; tick(); core_if.irq_ack_i = 1'b0;
    ext = 1'b0; lirq = '0; core_if.mret_i = 1'b1; tick(); core_if.mret_i = 1'b0;
    tick();
    chk("t1_quiet", core_if.irq_req_o, 1'b0);

    lirq = 8'h81;
    tick();
    chk("t2_mip", mip, 11'h408);
    tick();
    chk("t2_req",   core_if.irq_req_o,   1'b1);
    chk("t2_cause", core_if.irq_cause_o, 5'd23);
    core_if.irq_ack_i = 1'b1; tick(); core_if.irq_ack_i = 1'b0;
    lirq = '0; core_if.mret_i = 1'b1; tick(); core_if.mret_i = 1'b0;
    tick();

    mie = 11'h7FE; sw = 1'b1; tmr = 1'b1;
    tick(); tick();
    chk("t3_req",   core_if.irq_req_o,   1'b1);
    chk("t3_cause", core_if.irq_cause_o, 5'd7);
    tmr = 1'b0; gie = 1'b0;
    tick(); tick();
    chk("t3_hold_req",   core_if.irq_req_o,   1'b1);
    chk("t3_hold_cause", core_if.irq_cause_o, 5'd7);
    core_if.irq_ack_i = 1'b1; tick(); core_if.irq_ack_i = 1'b0;
    chk("t3_acked", core_if.irq_req_o, 1'b0);
    sw = 1'b0; core_if.mret_i = 1'b1; tick(); core_if.mret_i = 1'b0;
    gie = 1'b1; mie = '1;
    tick();
    chk("t3_quiet", core_if.irq_req_o, 1'b0);

    lirq = 8'h04; tick(); lirq = '0;
    chk("t4_mip_set", mip[5], 1'b1);
    tick();
    chk("t4_req",      core_if.irq_req_o,   1'b1);
    chk("t4_cause",    core_if.irq_cause_o, 5'd18);
    chk("t4_mip_hold", mip[5],              1'b1);
    core_if.irq_ack_i = 1'b1; tick(); core_if.irq_ack_i = 1'b0;
    chk("t4_mip_clr", mip[5], 1'b0);
    core_if.mret_i = 1'b1; tick(); core_if.mret_i = 1'b0;
    tick();
    chk("t4_quiet", core_if.irq_req_o, 1'b0);

    lirq = 8'h04; tick(); lirq = '0;
    tick();
    chk("t5_req", core_if.irq_req_o, 1'b1);
    core_if.irq_ack_i = 1'b1; lirq = 8'h04; tick();
    core_if.irq_ack_i = 1'b0; lirq = '0;
    chk("t5_mip_kept", mip[5], 1'b1);
    tick();
    chk("t5_busy",      core_if.irq_req_o, 1'b0);
    chk("t5_mip_kept2", mip[5],            1'b1);
    core_if.mret_i = 1'b1; tick(); core_if.mret_i = 1'b0;
    tick();
    chk("t5_rereq",  core_if.irq_req_o,   1'b1);
    chk("t5_rcause", core_if.irq_cause_o, 5'd18);
    core_if.irq_ack_i = 1'b1; tick(); core_if.irq_ack_i = 1'b0;
    core_if.mret_i = 1'b1; tick(); core_if.mret_i = 1'b0;
    tick();

    ext = 1'b1;
    tick(); tick();
    chk("t6_req",   core_if.irq_req_o,   1'b1);
    chk("t6_cause", core_if.irq_cause_o, 5'd11);
    core_if.irq_ack_i = 1'b1; tick(); core_if.irq_ack_i = 1'b0;
    rst_ni = 1'b0;
    #1;
    chk("t6_rst_req",   core_if.irq_req_o,   1'b0);
    chk("t6_rst_cause", core_if.irq_cause_o, 5'd0);
    chk("t6_rst_mip",   mip,                 11'h000);
    tick();
    rst_ni = 1'b1;
    tick();
    chk("t6_mip", mip,               11'h004);
    chk("t6_lat", core_if.irq_req_o, 1'b0);
    tick();
    chk("t6_rereq",  core_if.irq_req_o,   1'b1);
    chk("t6_rcause", core_if.irq_cause_o, 5'd11);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
